i2c_slave: RTL and testbench

- Responder end of the team's I2C bus; the counterpart to the I2C master on the same open-drain SCL/SDA pair.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, ACKs it, then receives write bytes or supplies read bytes through a simple byte-level user interface.
- Never drives SCL (no clock stretching); drives SDA low only, otherwise releases it.

---
 rtl/i2c_slave.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_slave.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C responder with fixed 7-bit address and byte-level user interface
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       byte_done, byte_done_n;
  logic [7:0] shift, shift_n;
  logic       sda_low, sda_low_n;
  logic       rw_n, busy_n, rx_valid_n, tx_req_n;
  logic [7:0] rx_data_n;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  // Open-drain pad: pull low or let the bus pull-up win.
  assign sda = sda_low ? 1'b0 : 1'bz;

  // Two-stage synchronizers plus one history stage for edge detection; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign sda_rise  = sda_s2 & ~sda_d;
  assign sda_fall  = ~sda_s2 & sda_d;
  assign start_det = sda_fall & scl_s2;
  assign stop_det  = sda_rise & scl_s2;

  // Protocol state and datapath registers; reset releases SDA at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      shift     <= 8'h00;
      sda_low   <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      byte_done <= byte_done_n;
      shift     <= shift_n;
      sda_low   <= sda_low_n;
      rw        <= rw_n;
      busy      <= busy_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      tx_req    <= tx_req_n;
    end
  end

  // Next-state logic: bus conditions first, then bit events per state.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    byte_done_n = byte_done;
    shift_n     = shift;
    sda_low_n   = sda_low;
    rw_n        = rw;
    busy_n      = busy;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    tx_req_n    = 1'b0;

    if (start_det) begin
      state_n     = ADDR;
      bit_cnt_n   = 3'd0;
      byte_done_n = 1'b0;
      sda_low_n   = 1'b0;
      busy_n      = 1'b0;
    end else if (stop_det) begin
      state_n     = IDLE;
      byte_done_n = 1'b0;
      sda_low_n   = 1'b0;
      busy_n      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sda_low_n = 1'b0;
        end

        ADDR, WR_DATA: begin
          if (scl_rise && !byte_done) begin
            shift_n   = {shift[6:0], sda_s2};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done_n = 1'b1;
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            bit_cnt_n   = 3'd0;
            if (state == ADDR) begin
              if (shift[7:1] == SLAVE_ADDR) begin
                rw_n      = shift[0];
                busy_n    = 1'b1;
                sda_low_n = 1'b1;
                state_n   = ADDR_ACK;
              end else begin
                sda_low_n = 1'b0;
                state_n   = WAIT_STOP;
              end
            end else begin
              rx_data_n  = shift;
              rx_valid_n = 1'b1;
              sda_low_n  = 1'b1;
              state_n    = WR_ACK;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = 3'd0;
            if (rw) begin
              tx_req_n  = 1'b1;
              shift_n   = tx_data;
              sda_low_n = ~tx_data[7];
              state_n   = RD_DATA;
            end else begin
              sda_low_n = 1'b0;
              state_n   = WR_DATA;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_low_n = 1'b0;
            state_n   = WR_DATA;
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_low_n   = 1'b0;
              byte_done_n = 1'b0;
              state_n     = RD_ACK;
            end else begin
              shift_n   = {shift[6:0], 1'b0};
              sda_low_n = ~shift[6];
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise && !byte_done) begin
            if (sda_s2) begin
              sda_low_n = 1'b0;
              busy_n    = 1'b0;
              state_n   = WAIT_STOP;
            end else begin
              byte_done_n = 1'b1;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            bit_cnt_n   = 3'd0;
            tx_req_n    = 1'b1;
            shift_n     = tx_data;
            sda_low_n   = ~tx_data[7];
            state_n     = RD_DATA;
          end
        end

        WAIT_STOP: begin
          sda_low_n = 1'b0;
          busy_n    = 1'b0;
        end

        default: begin
          state_n   = IDLE;
          sda_low_n = 1'b0;
          busy_n    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed self-checking bench for i2c_slave
module tb_i2c_slave;

  localparam int Q = 8;

  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       m_low;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rw;
  logic       busy;

  int checks;
  int failures;

  logic       mon_clr;
  int         rx_cnt;
  int         tx_cnt;
  logic [7:0] rx_log [0:7];
  logic       both_seen;
  logic       slave_low_seen;
  logic       busy_seen;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda_bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rw       (rw),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus/interface monitor, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (mon_clr) begin
      rx_cnt         = 0;
      tx_cnt         = 0;
      both_seen      = 1'b0;
      slave_low_seen = 1'b0;
      busy_seen      = 1'b0;
    end else begin
      if (rx_valid) begin
        if (rx_cnt < 8) rx_log[rx_cnt] = rx_data;
        rx_cnt = rx_cnt + 1;
      end
      if (tx_req) tx_cnt = tx_cnt + 1;
      if (rx_valid && tx_req) both_seen = 1'b1;
      if (!m_low && sda_bus === 1'b0) slave_low_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    wait_clk(2);
    mon_clr = 1'b0;
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_low = 1'b0;
    wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2 * Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    b = sda_bus;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
      if (i == 0) tx_data = next_tx;
    end
    write_bit(nack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda_bus); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (tx_req !== 1'b0) begin failures++; $display("FAIL reset_tx_req got=%b exp=0", tx_req); end
    checks++; if (rw !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b exp=0", rw); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    clear_mon();
    i2c_start();
    write_byte(8'hA0, a0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_after_addr got=%b exp=1", busy); end
    write_byte(8'hA5, a1);
    write_byte(8'h3C, a2);
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL wr_acks got=%b exp=000", {a0, a1, a2}); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_before_stop got=%b exp=1", busy); end
    i2c_stop();
    wait_clk(4);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
    checks++; if (rx_cnt !== 2) begin failures++; $display("FAIL wr_rx_count got=%0d exp=2", rx_cnt); end
    checks++; if (rx_log[0] !== 8'hA5) begin failures++; $display("FAIL wr_byte0 got=%h exp=a5", rx_log[0]); end
    checks++; if (rx_log[1] !== 8'h3C) begin failures++; $display("FAIL wr_byte1 got=%h exp=3c", rx_log[1]); end
    checks++; if (rw !== 1'b0) begin failures++; $display("FAIL wr_rw got=%b exp=0", rw); end
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] d0, d1, d2;
    clear_mon();
    tx_data = 8'h81;
    i2c_start();
    write_byte(8'hA1, a0);
    checks++; if (a0 !== 1'b0) begin failures++; $display("FAIL rd_addr_ack got=%b exp=0", a0); end
    checks++; if (rw !== 1'b1) begin failures++; $display("FAIL rd_rw got=%b exp=1", rw); end
    read_byte(1'b0, 8'h7E, d0);
    read_byte(1'b0, 8'hFF, d1);
    read_byte(1'b1, 8'h00, d2);
    checks++; if (d0 !== 8'h81) begin failures++; $display("FAIL rd_byte0 got=%h exp=81", d0); end
    checks++; if (d1 !== 8'h7E) begin failures++; $display("FAIL rd_byte1 got=%h exp=7e", d1); end
    checks++; if (d2 !== 8'hFF) begin failures++; $display("FAIL rd_byte2 got=%h exp=ff", d2); end
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL rd_sda_after_nack got=%b exp=1", sda_bus); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_after_nack got=%b exp=0", busy); end
    i2c_stop();
    wait_clk(4);
    checks++; if (tx_cnt !== 3) begin failures++; $display("FAIL rd_tx_req_count got=%0d exp=3", tx_cnt); end
    checks++; if (rx_cnt !== 0) begin failures++; $display("FAIL rd_rx_count got=%0d exp=0", rx_cnt); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    clear_mon();
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h12, a1);
    i2c_stop();
    wait_clk(4);
    checks++; if ({a0, a1} !== 2'b11) begin failures++; $display("FAIL mm_acks got=%b exp=11", {a0, a1}); end
    checks++; if (slave_low_seen !== 1'b0) begin failures++; $display("FAIL mm_sda_driven got=%b exp=0", slave_low_seen); end
    checks++; if (rx_cnt !== 0) begin failures++; $display("FAIL mm_rx_count got=%0d exp=0", rx_cnt); end
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL mm_busy_seen got=%b exp=0", busy_seen); end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2;
    logic [7:0] d0;
    clear_mon();
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h04, a1);
    checks++; if (rx_data !== 8'h04) begin failures++; $display("FAIL rs_rx_data got=%h exp=04", rx_data); end
    checks++; if (rw !== 1'b0) begin failures++; $display("FAIL rs_rw_write got=%b exp=0", rw); end
    tx_data = 8'hC3;
    i2c_start();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rs_busy_after_rstart got=%b exp=0", busy); end
    write_byte(8'hA1, a2);
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL rs_acks got=%b exp=000", {a0, a1, a2}); end
    checks++; if (rw !== 1'b1) begin failures++; $display("FAIL rs_rw_read got=%b exp=1", rw); end
    read_byte(1'b1, 8'h00, d0);
    checks++; if (d0 !== 8'hC3) begin failures++; $display("FAIL rs_read_byte got=%h exp=c3", d0); end
    i2c_stop();
    wait_clk(4);
    checks++; if (rx_cnt !== 1 || tx_cnt !== 1) begin failures++; $display("FAIL rs_pulse_counts got=%0d/%0d exp=1/1", rx_cnt, tx_cnt); end
  endtask

  task automatic test_abort();
    logic a0;
    logic [7:0] addr_byte;
    clear_mon();
    i2c_start();
    write_byte(8'hA0, a0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    wait_clk(4);
    checks++; if (rx_cnt !== 0) begin failures++; $display("FAIL ab_rx_count got=%0d exp=0", rx_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ab_busy got=%b exp=0", busy); end
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL ab_sda got=%b exp=1", sda_bus); end

    addr_byte = 8'hA0;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(addr_byte[i]);
    m_low = 1'b0;
    wait_clk(1);
    checks++; if (sda_bus !== 1'b0) begin failures++; $display("FAIL ab_ack_low got=%b exp=0", sda_bus); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ab_busy_before_reset got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL ab_reset_sda got=%b exp=1", sda_bus); end
    checks++; if ({busy, rw, rx_valid, tx_req} !== 4'b0000) begin failures++; $display("FAIL ab_reset_flags got=%b exp=0000", {busy, rw, rx_valid, tx_req}); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL ab_reset_rx_data got=%h exp=00", rx_data); end
    wait_clk(2);
    scl = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    scl      = 1'b1;
    m_low    = 1'b0;
    tx_data  = 8'h00;
    mon_clr  = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_abort();
    checks++; if (both_seen !== 1'b0) begin failures++; $display("FAIL rx_tx_same_cycle got=%b exp=0", both_seen); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
